// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: NUM_REQ internal requesters share one APB slave port.
// Registered APB controls; per-requester one-cycle response pulse with PSLVERR/timeout error.
module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [STRB_WIDTH-1:0]            pstrb,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

    state_e                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [TW-1:0]           cnt_q, cnt_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [IDW:0]            pick;
    logic                    any_req;
    logic [IDW-1:0]          win;
    logic                    capture;

    // Returns {found, index}: first valid requester at or above ptr, wrapping around.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDW-1:0]     ptr);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] jj;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j  = (int'(ptr) + k) % NUM_REQ;
            jj = IDW'(j);
            if (!found && vld[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
        return {found, idx};
    endfunction

    assign pick    = rr_pick(req_valid, ptr_q);
    assign any_req = pick[IDW];
    assign win     = pick[IDW-1:0];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        capture     = 1'b0;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (any_req) capture = 1'b1;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                if (pready) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : prdata;
                    rsp_err_d            = pslverr;
                    if (any_req) capture = 1'b1;
                    else         state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT > 0 && cnt_d == TO_VAL) begin
                        rsp_valid_d[grant_q] = 1'b1;
                        rsp_err_d            = 1'b1;
                        state_d              = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Capture always lands in SETUP, so a completion never chains straight into ACCESS.
        if (capture) begin
            req_ready[win] = !preset;
            state_d        = S_SETUP;
            grant_d        = win;
            ptr_d          = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            pwrite_d       = req_write[win];
            paddr_d        = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d       = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            pstrb_d        = req_write[win] ? req_strb[int'(win)*STRB_WIDTH +: STRB_WIDTH] : '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign psel      = (state_q != S_IDLE);
    assign penable   = (state_q == S_ACCESS);
    assign busy      = psel;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign grant_id  = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a scoreboard of expected responses
// and a simple APB slave model (configurable wait states, hang, PSLVERR at 0xFF).
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;

    logic              pclk = 1'b0;
    logic              preset;
    logic [N-1:0]      req_valid, req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_strb;
    logic [N-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [1:0]        grant_id;
    logic              busy, psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic [DW-1:0]     prdata;
    logic              pready, pslverr;

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .grant_id(grant_id), .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t          sb[$];
    int            grants[$];
    int            checks = 0;
    int            errors = 0;
    int            nresp = 0;
    int            b2b = 0;
    logic          prev_done = 1'b0;
    logic [N-1:0]  acc_mask = '0;
    int            wait_cfg = 0;
    bit            hang = 1'b0;
    int            acc_cnt = 0;
    logic          r_write [N];
    logic [AW-1:0] r_addr [N];

    logic [N-1:0]  s_rr, s_rv;
    logic [DW-1:0] s_rdata, s_pwdata;
    logic [AW-1:0] s_paddr;
    logic [SW-1:0] s_pstrb;
    logic [1:0]    s_gid;
    logic          s_err, s_psel, s_pen, s_pwrite, s_busy;

    function automatic logic [31:0] slave_data(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {a, ~a, 16'hB00C};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score at negedge, then after the edge retire accepted
    // requests and update the slave model.
    task automatic tick();
        exp_t e;
        @(negedge pclk);
        s_rr = req_ready;  s_rv = rsp_valid;  s_rdata = rsp_rdata;  s_err = rsp_err;
        s_psel = psel;     s_pen = penable;   s_paddr = paddr;      s_pwdata = pwdata;
        s_pstrb = pstrb;   s_pwrite = pwrite; s_busy = busy;        s_gid = grant_id;
        if (prev_done && penable && pready) b2b++;
        prev_done = penable && pready;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                grants.push_back(i);
                acc_mask[i] = 1'b1;
                e.id = 2'(i);
                if (hang) begin
                    e.rdata = '0;
                    e.err   = 1'b1;
                end else begin
                    e.rdata = r_write[i] ? 32'h0 : slave_data(r_addr[i]);
                    e.err   = (r_addr[i] == 8'hFF);
                end
                sb.push_back(e);
            end
        end
        if (|rsp_valid) begin
            nresp++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_id", 32'(rsp_valid), 32'd1 << e.id);
                check("sb_rdata", rsp_rdata, e.rdata);
                check("sb_err", 32'(rsp_err), 32'(e.err));
            end
        end
        @(posedge pclk);
        #1;
        req_valid = req_valid & ~acc_mask;
        acc_mask  = '0;
        if (psel && penable) acc_cnt++;
        else                 acc_cnt = 0;
        pready  = psel && penable && !hang && (acc_cnt > wait_cfg);
        pslverr = psel && penable && (paddr == 8'hFF);
        prdata  = (psel && penable) ? slave_data(paddr) : 32'h0;
    endtask

    task automatic set_req(input int id, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        r_write[id] = w;
        r_addr[id]  = a;
        req_write[id]            = w;
        req_addr[id*AW +: AW]    = a;
        req_wdata[id*DW +: DW]   = d;
        req_strb[id*SW +: SW]    = s;
        req_valid[id]            = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int n0 = nresp;
        int c  = 0;
        while ((nresp - n0) < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, 32'(nresp - n0), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pen_cnt;
        int psel_low;
        int cyc;
        int n0;

        preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        for (int i = 0; i < N; i++) begin r_write[i] = 1'b0; r_addr[i] = '0; end
        repeat (3) tick();

        check("rst_psel",    32'(s_psel), 32'd0);
        check("rst_penable", 32'(s_pen), 32'd0);
        check("rst_pwrite",  32'(s_pwrite), 32'd0);
        check("rst_paddr",   32'(s_paddr), 32'd0);
        check("rst_pwdata",  s_pwdata, 32'd0);
        check("rst_pstrb",   32'(s_pstrb), 32'd0);
        check("rst_req_rdy", 32'(s_rr), 32'd0);
        check("rst_rsp_vld", 32'(s_rv), 32'd0);
        check("rst_rdata",   s_rdata, 32'd0);
        check("rst_err",     32'(s_err), 32'd0);
        check("rst_busy",    32'(s_busy), 32'd0);
        check("rst_gid",     32'(s_gid), 32'd0);

        // single zero-wait read from requester 1
        preset = 1'b0;
        tick();
        set_req(1, 1'b0, 8'h10, 32'h0, 4'hF);
        tick();
        check("t1_ready", 32'(s_rr), 32'b0010);
        check("t1_busy0", 32'(s_busy), 32'd0);
        tick();
        check("t1_setup_psel", 32'(s_psel), 32'd1);
        check("t1_setup_pen",  32'(s_pen), 32'd0);
        check("t1_paddr",      32'(s_paddr), 32'h10);
        check("t1_pstrb_rd",   32'(s_pstrb), 32'd0);
        tick();
        check("t1_access_pen", 32'(s_pen), 32'd1);
        tick();
        check("t1_rsp_vld",   32'(s_rv), 32'b0010);
        check("t1_rsp_rdata", s_rdata, 32'hDEADBEEF);
        check("t1_rsp_err",   32'(s_err), 32'd0);
        check("t1_gid",       32'(s_gid), 32'd1);

        // write with three wait states from requester 0
        wait_cfg = 3;
        set_req(0, 1'b1, 8'h04, 32'hA5A5A5A5, 4'hF);
        tick();
        check("t2_ready", 32'(s_rr), 32'b0001);
        tick();
        check("t2_setup_pen", 32'(s_pen), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_pen",    32'(s_pen), 32'd1);
            check("t2_paddr",  32'(s_paddr), 32'h04);
            check("t2_pwdata", s_pwdata, 32'hA5A5A5A5);
            check("t2_pstrb",  32'(s_pstrb), 32'hF);
            check("t2_pwrite", 32'(s_pwrite), 32'd1);
            check("t2_no_rsp", 32'(s_rv), 32'd0);
        end
        tick();
        check("t2_rsp_vld", 32'(s_rv), 32'b0001);
        check("t2_rsp_err", 32'(s_err), 32'd0);
        wait_cfg = 0;

        // all four requesters from reset: 0,1,2,3 back to back via SETUP
        preset = 1'b1;
        tick();
        preset = 1'b0;
        sb.delete();
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h80 + i), 32'h0, 4'h0);
        b2b = 0; psel_low = 0; cyc = 0; n0 = nresp;
        while ((nresp - n0) < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (!s_psel) psel_low++;
        end
        check("t3_resp_cnt", 32'(nresp - n0), 32'd4);
        check("t3_cycles",   32'(cyc), 32'd10);
        check("t3_psel_low", 32'(psel_low), 32'd2);
        check("t3_b2b",      32'(b2b), 32'd0);
        check("t3_ngrant",   32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_order", 32'(grants[i]), 32'(i));

        // slave hangs: abort after 16 ACCESS cycles
        hang = 1'b1;
        set_req(2, 1'b0, 8'h20, 32'h0, 4'h0);
        pen_cnt = 0; cyc = 0; n0 = nresp;
        while (nresp == n0 && cyc < 40) begin
            tick();
            cyc++;
            if (s_pen) pen_cnt++;
        end
        check("t4_done",    32'(nresp - n0), 32'd1);
        check("t4_pen_cnt", 32'(pen_cnt), 32'd16);
        check("t4_rsp_vld", 32'(s_rv), 32'b0100);
        check("t4_err",     32'(s_err), 32'd1);
        check("t4_rdata",   s_rdata, 32'd0);
        check("t4_psel",    32'(s_psel), 32'd0);
        hang = 1'b0;
        set_req(3, 1'b0, 8'h33, 32'h0, 4'h0);
        run_until(1, 20, "t4_next_done");
        check("t4_next_vld",   32'(s_rv), 32'b1000);
        check("t4_next_err",   32'(s_err), 32'd0);
        check("t4_next_rdata", s_rdata, slave_data(8'h33));

        // PSLVERR at 0xFF, followed by a clean transfer
        set_req(0, 1'b1, 8'hFF, 32'h12345678, 4'h3);
        run_until(1, 20, "t5_err_done");
        check("t5_err_vld", 32'(s_rv), 32'b0001);
        check("t5_err",     32'(s_err), 32'd1);
        set_req(1, 1'b0, 8'h30, 32'h0, 4'h0);
        run_until(1, 20, "t5_ok_done");
        check("t5_ok_err",   32'(s_err), 32'd0);
        check("t5_ok_rdata", s_rdata, slave_data(8'h30));

        // reset in the middle of requester 2's ACCESS
        hang = 1'b1;
        set_req(2, 1'b0, 8'h40, 32'h0, 4'h0);
        tick();
        check("t6_ready", 32'(s_rr), 32'b0100);
        repeat (3) tick();
        check("t6_in_access", 32'(s_pen), 32'd1);
        set_req(2, 1'b0, 8'h44, 32'h0, 4'h0);
        set_req(3, 1'b0, 8'h48, 32'h0, 4'h0);
        preset = 1'b1;
        tick();
        tick();
        check("t6_rst_psel", 32'(s_psel), 32'd0);
        check("t6_rst_pen",  32'(s_pen), 32'd0);
        check("t6_rst_rsp",  32'(s_rv), 32'd0);
        check("t6_rst_rdy",  32'(s_rr), 32'd0);
        preset = 1'b0;
        hang = 1'b0;
        sb.delete();
        grants.delete();
        tick();
        check("t6_first_rdy", 32'(s_rr), 32'b0100);
        check("t6_no_rsp",    32'(s_rv), 32'd0);
        run_until(2, 30, "t6_done");
        check("t6_ngrant", 32'(grants.size()), 32'd2);
        check("t6_g0",     32'(grants[0]), 32'd2);
        check("t6_g1",     32'(grants[1]), 32'd3);
        check("sb_drain",  32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin APB master that shares one APB slave port among NUM_REQ internal requesters.
- Sequences IDLE/SETUP/ACCESS phases and holds PADDR/PWRITE/PWDATA/PSTRB stable from SETUP to the end of ACCESS.
- Returns PRDATA and PSLVERR to the granted requester.
- Aborts with an error response when PREADY is not seen within TIMEOUT cycles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 8, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- STRB_WIDTH, DATA_WIDTH/8, PSTRB width
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request pending per requester
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*STRB_WIDTH  packed write strobes
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; valid only with rsp_valid
- rsp_err  out  1  PSLVERR or timeout; valid only with rsp_valid
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- busy  out  1  high in SETUP or ACCESS
- psel, penable, pwrite  out  1  APB master controls
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  STRB_WIDTH  APB strobes; forced 0 on reads
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset (preset high at a pclk edge), outputs after that edge:
  - psel=penable=pwrite=0; paddr=pwdata=pstrb=0
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, grant_id=0
  - state=IDLE; round-robin pointer=0; timeout counter=0
  - A reset asserted mid-SETUP or mid-ACCESS drops psel/penable at that edge and issues no rsp_valid.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: psel=0, penable=0. If any req_valid, the winner W is chosen combinationally; req_ready[W]=1 this cycle. At the edge: capture W's addr/write/wdata/strb into the APB output registers, grant_id<=W, go to SETUP.
  - SETUP: psel=1, penable=0. Unconditionally go to ACCESS at the next edge; clear the timeout counter.
  - ACCESS: psel=1, penable=1.
    - pready=1: transfer completes at this edge. rsp_valid[grant_id]<=1 for exactly one cycle; rsp_rdata<=prdata on reads, else 0; rsp_err<=pslverr.
    - pready=0: increment the counter. When the counter reaches TIMEOUT (TIMEOUT>0), abort: rsp_valid pulse with rsp_err=1 and rsp_rdata=0, psel<=0, go to IDLE.
  - Completion with another req_valid pending: a new winner is arbitrated in the same cycle. req_ready pulses, the new request is captured, and the next state is SETUP with psel held high and penable=0. There are never back-to-back ACCESS cycles.
  - Completion with nothing pending: go to IDLE.
- Arbitration:
  - Round-robin, searching from pointer upward with wrap-around.
  - After a grant to W, pointer<=(W+1) mod NUM_REQ.
  - A requester with req_valid held waits at most NUM_REQ-1 grants.
- Requester contract:
  - Hold req_valid and its fields stable until req_ready.
  - req_valid may be deasserted only after the req_ready cycle.
  - The arbiter never accepts from a requester whose req_valid is low.
- Stability: paddr/pwrite/pwdata/pstrb change only at a capture edge, never between SETUP and completion.
- Latency (zero-wait slave):
  - req_ready cycle 0; SETUP cycle 1; ACCESS cycle 2; rsp_valid cycle 3.
  - Each PREADY wait state adds one cycle.
- Simultaneous rsp_valid to A and req_ready to B in the same cycle is legal.

Test Plan:
- Single read, requester 1, addr 0x10, zero-wait, prdata=0xDEADBEEF -> req_ready[1] cycle 0, psel cycle 1, penable cycle 2, rsp_valid[1] cycle 3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write addr 0x04, wdata 0xA5A5A5A5, strb 0xF; slave inserts 3 wait states -> penable high 4 cycles, paddr/pwdata/pstrb unchanged throughout, rsp_valid on the 4th ACCESS cycle +1.
- All 4 requesters assert req_valid together from reset -> grant order 0,1,2,3. SETUP follows each completion with psel held high and penable low; no two consecutive penable-high-with-pready cycles.
- Slave never asserts pready, TIMEOUT=16 -> abort after 16 ACCESS cycles: rsp_err=1, rsp_rdata=0, psel low, next request served normally.
- Slave returns pslverr=1 for addr 0xFF -> rsp_err=1 on the matching rsp_valid; the next transfer reports rsp_err=0.
- preset high during ACCESS of requester 2 -> psel=penable=0 the next cycle, no rsp_valid[2]. After reset releases with req_valid[2] still high, requester 2 is granted first (pointer=0 and no lower requester pending).
